// File: rtl/pi_gpio_mux.sv
// pi_gpio_mux: register-configured pin multiplexer for the Raspberry Pi GPIO
// header. Routes each pin to a software GPIO bit, its fixed peripheral (ALT)
// function, or parks it in high-Z. Adds input synchronisation, edge-detect
// interrupts and, when PI_GPIO_MUX_DEBOUNCE_EN is defined, per-pin debounce.
//
// Register map (word address): 0 OUT, 1 DIR, 2 IN (RO), 3 FUNC_LO, 4 FUNC_HI,
// 5 RISE_EN, 6 FALL_EN, 7 PEND (write 1 to clear).
module pi_gpio_mux #(
    parameter int              PINS            = 28,
    parameter int              SYNC_STAGES     = 2,
    parameter logic [PINS-1:0] ALT_MASK        = PINS'(28'h0FFFFFF),
    parameter int              DEBOUNCE_CYCLES = 1000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [PINS-1:0] pin_i,
    output logic [PINS-1:0] pin_o,
    output logic [PINS-1:0] pin_t,
    input  logic [PINS-1:0] alt_o,
    input  logic [PINS-1:0] alt_t,
    output logic [PINS-1:0] alt_i,
    input  logic            reg_wr,
    input  logic            reg_rd,
    input  logic [2:0]      reg_addr,
    input  logic [31:0]     reg_wdata,
    output logic [31:0]     reg_rdata,
    output logic            reg_ack,
    output logic            irq
);

    localparam logic [1:0] FUNC_GPIO = 2'd0;
    localparam logic [1:0] FUNC_ALT  = 2'd1;

    // A pin without a peripheral cannot be put in ALT mode; it falls back to GPIO.
    function automatic logic [1:0] filter_func(input logic [1:0] code, input logic has_alt);
        if (code == FUNC_ALT && !has_alt) begin
            return FUNC_GPIO;
        end
        return code;
    endfunction

    logic [PINS-1:0] sync_p [SYNC_STAGES];
    logic [PINS-1:0] sync_val;
    logic [PINS-1:0] in_val;
    logic [PINS-1:0] in_prev;

    logic [PINS-1:0] out_q;
    logic [PINS-1:0] dir_q;
    logic [PINS-1:0] rise_q;
    logic [PINS-1:0] fall_q;
    logic [PINS-1:0] pend_q;
    logic [1:0]      func_q    [PINS];
    logic [1:0]      func_next [PINS];

    logic [PINS-1:0] wdata_pins;
    logic [PINS-1:0] edge_set;
    logic [PINS-1:0] pend_clr;
    logic [PINS-1:0] route_o;
    logic [PINS-1:0] route_t;
    logic [31:0]     func_lo;
    logic [31:0]     func_hi;
    logic [31:0]     rd_word;
    logic            unused_wdata;

    assign wdata_pins   = reg_wdata[PINS-1:0];
    assign unused_wdata = ^reg_wdata;
    assign sync_val     = sync_p[SYNC_STAGES-1];

    // Input synchroniser chain: pad value crosses SYNC_STAGES flops before use.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_p[k] <= '0;
            end
        end else begin
            sync_p[0] <= pin_i;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_p[k] <= sync_p[k-1];
            end
        end
    end

`ifdef PI_GPIO_MUX_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic [CNT_W-1:0] db_cnt [PINS];
    logic [PINS-1:0]  in_q;

    // Debounce: accept a new level only after it has persisted DEBOUNCE_CYCLES cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            in_q <= '0;
            for (int n = 0; n < PINS; n++) begin
                db_cnt[n] <= '0;
            end
        end else begin
            for (int n = 0; n < PINS; n++) begin
                if (sync_val[n] == in_q[n]) begin
                    db_cnt[n] <= '0;
                end else if (db_cnt[n] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    in_q[n]   <= sync_val[n];
                    db_cnt[n] <= '0;
                end else begin
                    db_cnt[n] <= db_cnt[n] + CNT_W'(1);
                end
            end
        end
    end

    assign in_val = in_q;
`else
    assign in_val = sync_val;
`endif

    assign alt_i = in_val;

    // Edge flags are qualified by the enables when they are raised, so irq needs no mask.
    assign edge_set = (in_val & ~in_prev & rise_q) | (~in_val & in_prev & fall_q);
    assign pend_clr = (reg_wr && reg_addr == 3'd7) ? wdata_pins : '0;
    assign irq      = |pend_q;

    // Next FUNC codes: each half-register write updates only the pins it covers.
    always_comb begin
        for (int n = 0; n < PINS; n++) begin
            func_next[n] = func_q[n];
            if (reg_wr && ((n < 16 && reg_addr == 3'd3) || (n >= 16 && reg_addr == 3'd4))) begin
                func_next[n] = filter_func(reg_wdata[(n % 16) * 2 +: 2], ALT_MASK[n]);
            end
        end
    end

    // Per-pin routing selected by FUNC; reserved code behaves as OFF.
    always_comb begin
        route_o = '0;
        route_t = '1;
        for (int n = 0; n < PINS; n++) begin
            case (func_q[n])
                2'd0: begin
                    route_o[n] = out_q[n];
                    route_t[n] = ~dir_q[n];
                end
                2'd1: begin
                    route_o[n] = alt_o[n];
                    route_t[n] = alt_t[n];
                end
                default: begin
                    route_o[n] = 1'b0;
                    route_t[n] = 1'b1;
                end
            endcase
        end
    end

    // Read mux: pack FUNC codes and zero-extend the per-pin registers.
    always_comb begin
        func_lo = '0;
        func_hi = '0;
        for (int n = 0; n < PINS; n++) begin
            if (n < 16) begin
                func_lo[(n % 16) * 2 +: 2] = func_q[n];
            end else begin
                func_hi[(n % 16) * 2 +: 2] = func_q[n];
            end
        end
        case (reg_addr)
            3'd0:    rd_word = 32'(out_q);
            3'd1:    rd_word = 32'(dir_q);
            3'd2:    rd_word = 32'(in_val);
            3'd3:    rd_word = func_lo;
            3'd4:    rd_word = func_hi;
            3'd5:    rd_word = 32'(rise_q);
            3'd6:    rd_word = 32'(fall_q);
            default: rd_word = 32'(pend_q);
        endcase
    end

    // Configuration registers, edge history and pending flags (set beats clear).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_q   <= '0;
            dir_q   <= '0;
            rise_q  <= '0;
            fall_q  <= '0;
            pend_q  <= '0;
            in_prev <= '0;
            for (int n = 0; n < PINS; n++) begin
                func_q[n] <= FUNC_GPIO;
            end
        end else begin
            in_prev <= in_val;
            pend_q  <= (pend_q & ~pend_clr) | edge_set;
            for (int n = 0; n < PINS; n++) begin
                func_q[n] <= func_next[n];
            end
            if (reg_wr) begin
                case (reg_addr)
                    3'd0:    out_q  <= wdata_pins;
                    3'd1:    dir_q  <= wdata_pins;
                    3'd5:    rise_q <= wdata_pins;
                    3'd6:    fall_q <= wdata_pins;
                    default: ;
                endcase
            end
        end
    end

    // Register access response: ack one cycle after each strobe, read data holds.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            reg_ack   <= 1'b0;
            reg_rdata <= '0;
        end else begin
            reg_ack <= reg_wr | reg_rd;
            if (reg_rd) begin
                reg_rdata <= rd_word;
            end
        end
    end

    // Registered pad drive.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pin_o <= '0;
            pin_t <= '1;
        end else begin
            pin_o <= route_o;
            pin_t <= route_t;
        end
    end

endmodule
